// File: rtl/mfp_ahb_uart_tx_if.sv
// AHB-Lite slave-side bus bundle for the UART transmitter.
// The decoder/master drives the address/control/write-data side; the slave returns read data and response.
interface mfp_ahb_uart_tx_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/mfp_ahb_uart_tx.sv
// AHB-Lite UART transmitter: memory-mapped TX FIFO feeding an 8N1 shifter.
// The bit period is programmable and is latched at the start of every frame.
module mfp_ahb_uart_tx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 434
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  mfp_ahb_uart_tx_if.slave      ahb,
  output logic                  UART_TX,
  output logic                  TX_EMPTY
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [1:0] A_TXDATA  = 2'd0;
  localparam logic [1:0] A_STATUS  = 2'd1;
  localparam logic [1:0] A_DIVISOR = 2'd2;

  // Bus address phase capture
  logic       dphase_reg;
  logic       dwrite_reg;
  logic [1:0] daddr_reg;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dphase_reg <= 1'b0;
      dwrite_reg <= 1'b0;
      daddr_reg  <= 2'd0;
    end else begin
      dphase_reg <= ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
      if (ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY) begin
        dwrite_reg <= ahb.HWRITE;
        daddr_reg  <= ahb.HADDR[3:2];
      end
    end
  end

  logic wr_en, push, ovf_clr, div_wr;
  assign wr_en   = dphase_reg & dwrite_reg;
  assign push    = wr_en & (daddr_reg == A_TXDATA);
  assign ovf_clr = wr_en & (daddr_reg == A_STATUS) & ahb.HWDATA[3];
  assign div_wr  = wr_en & (daddr_reg == A_DIVISOR);

  logic [15:0] divisor_reg;
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      divisor_reg <= 16'(DEFAULT_DIV);
    end else if (div_wr) begin
      divisor_reg <= (ahb.HWDATA[15:1] == 15'd0) ? 16'd2 : ahb.HWDATA[15:0];
    end
  end

  // TX FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_reg, rptr_reg;
  logic [CW-1:0] count_reg;
  logic          ovf_reg;
  logic          full, empty, pop, push_ok;

  assign full    = (count_reg == CW'(FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  // A pop on the same edge frees the slot the push needs, so a full FIFO still accepts it
  assign push_ok = push & (~full | pop);

  always_ff @(posedge HCLK) begin
    if (push_ok) begin
      mem[wptr_reg] <= ahb.HWDATA[7:0];
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      if (push_ok) wptr_reg <= wptr_reg + 1'b1;
      if (pop)     rptr_reg <= rptr_reg + 1'b1;
      count_reg <= count_reg + CW'(push_ok) - CW'(pop);
      if (push & ~push_ok)  ovf_reg <= 1'b1;
      else if (ovf_clr)     ovf_reg <= 1'b0;
    end
  end

  // Serial shifter FSM
  logic [1:0]  state_reg, state_next;
  logic [15:0] tick_reg, tick_next;
  logic [15:0] div_lat_reg, div_lat_next;
  logic [2:0]  bitcnt_reg, bitcnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic        tx_reg, tx_next;
  logic        tick_done, busy;

  assign tick_done = (tick_reg == div_lat_reg - 16'd1);
  assign busy      = (state_reg != ST_IDLE);
  assign pop       = ~empty & ((state_reg == ST_IDLE) | ((state_reg == ST_STOP) & tick_done));

  always_comb begin
    state_next   = state_reg;
    tick_next    = tick_reg;
    div_lat_next = div_lat_reg;
    bitcnt_next  = bitcnt_reg;
    shift_next   = shift_reg;
    tx_next      = tx_reg;
    if (pop) begin
      // Covers both the idle start and the gapless STOP -> START chaining
      state_next   = ST_START;
      tick_next    = '0;
      div_lat_next = divisor_reg;
      bitcnt_next  = '0;
      shift_next   = mem[rptr_reg];
      tx_next      = 1'b0;
    end else begin
      case (state_reg)
        ST_START: begin
          if (tick_done) begin
            tick_next  = '0;
            state_next = ST_DATA;
            tx_next    = shift_reg[0];
          end else begin
            tick_next = tick_reg + 16'd1;
          end
        end
        ST_DATA: begin
          if (tick_done) begin
            tick_next = '0;
            if (bitcnt_reg == 3'd7) begin
              state_next = ST_STOP;
              tx_next    = 1'b1;
            end else begin
              shift_next  = shift_reg >> 1;
              tx_next     = shift_reg[1];
              bitcnt_next = bitcnt_reg + 3'd1;
            end
          end else begin
            tick_next = tick_reg + 16'd1;
          end
        end
        ST_STOP: begin
          if (tick_done) begin
            tick_next  = '0;
            state_next = ST_IDLE;
            tx_next    = 1'b1;
          end else begin
            tick_next = tick_reg + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_reg   <= ST_IDLE;
      tick_reg    <= '0;
      div_lat_reg <= 16'(DEFAULT_DIV);
      bitcnt_reg  <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      tick_reg    <= tick_next;
      div_lat_reg <= div_lat_next;
      bitcnt_reg  <= bitcnt_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
    end
  end

  assign UART_TX  = tx_reg;
  assign TX_EMPTY = empty & ~busy;

  // Read data path
  logic [8:0]  count_ext;
  logic [31:0] rdata;
  assign count_ext = 9'(count_reg);

  always_comb begin
    rdata = 32'd0;
    if (dphase_reg & ~dwrite_reg) begin
      case (daddr_reg)
        A_STATUS:  rdata = {16'd0, count_ext[7:0], 4'd0, ovf_reg, full, empty, busy};
        A_DIVISOR: rdata = {16'd0, divisor_reg};
        default:   rdata = 32'd0;
      endcase
    end
  end

  assign ahb.HRDATA    = rdata;
  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{ahb.HADDR[31:4], ahb.HADDR[1:0], ahb.HTRANS[0], ahb.HWDATA[31:16]};
endmodule
